register_file_mp: RTL

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp_if.sv | 29 ++
 rtl/register_file_mp.sv | 100 ++++++++++
 2 files changed

// File: rtl/register_file_mp_if.sv
// Register file bus: two registered read ports, one write port, scrub control and status.
// The master side drives requests; the slave side returns read data, busy and wr_drop.
interface register_file_mp_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  logic             rd_en_a;
  logic [AW-1:0]    rd_sel_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_sel_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             wr_en;
  logic [AW-1:0]    wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             scrub;
  logic             busy;
  logic             wr_drop;

  modport master (
    output rd_en_a, rd_sel_a, rd_en_b, rd_sel_b, wr_en, wr_sel, wr_data, scrub,
    input  rd_data_a, rd_data_b, busy, wr_drop
  );

  modport slave (
    input  rd_en_a, rd_sel_a, rd_en_b, rd_sel_b, wr_en, wr_sel, wr_data, scrub,
    output rd_data_a, rd_data_b, busy, wr_drop
  );
endinterface

// File: rtl/register_file_mp.sv
// 2R1W register file, regs 0-3 constant, 1-cycle registered reads, scrub FSM zeroes regs 4..DEPTH-1.
// No backpressure: writes during scrub or to constants are dropped (wr_drop); REGFILE_BYPASS_EN forwards same-cycle writes.
module register_file_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic               clk,
  input logic               clear_n,
  register_file_mp_if.slave bus
);

  typedef enum logic {IDLE, SCRUB} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic [WIDTH-1:0] rd_word_a, rd_word_b;
  logic             wr_drop_q, wr_drop_d;
  logic             wr_acc;
  logic             busy;

  // Constant registers are decoded here; their storage slots are never written.
  function automatic logic [WIDTH-1:0] reg_value(input logic [AW-1:0] sel,
                                                 input logic [WIDTH-1:0] stored);
    logic [WIDTH-1:0] v;
    case (sel)
      AW'(0):  v = '0;
      AW'(1):  v = WIDTH'(1);
      AW'(2):  v = {1'b1, {(WIDTH-1){1'b0}}};
      AW'(3):  v = '1;
      default: v = stored;
    endcase
    return v;
  endfunction

  assign busy      = (state_q == SCRUB);
  assign wr_acc    = bus.wr_en && (bus.wr_sel >= AW'(4)) && !busy && !bus.scrub;
  assign wr_drop_d = bus.wr_en && !wr_acc;

  always_comb begin
    rd_word_a = reg_value(bus.rd_sel_a, mem_q[bus.rd_sel_a]);
    rd_word_b = reg_value(bus.rd_sel_b, mem_q[bus.rd_sel_b]);
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (bus.wr_sel == bus.rd_sel_a)) rd_word_a = bus.wr_data;
    if (wr_acc && (bus.wr_sel == bus.rd_sel_b)) rd_word_b = bus.wr_data;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.scrub) begin
          state_d = SCRUB;
          cnt_d   = AW'(4);
        end
      end
      SCRUB: begin
        // Last address leaves the counter parked rather than wrapping to 0.
        if (cnt_q == AW'(DEPTH-1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      wr_drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      if (bus.rd_en_a) rd_data_a_q <= rd_word_a;
      if (bus.rd_en_b) rd_data_b_q <= rd_word_b;
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_acc) begin
        mem_q[bus.wr_sel] <= bus.wr_data;
      end
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.busy      = busy;
  assign bus.wr_drop   = wr_drop_q;

endmodule
